wb_arbiter2: RTL and testbench
==============================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 Parameter ADW, default 30, word address width (byte address bits [31:2]).
REQ-002 Parameter DW, default 32, data width; select width is DW/8.
REQ-003 Parameter TIMEOUT, default 255, max cycles a strobe may wait for ack/err before the arbiter terminates it.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 mN_cyc_i  input  1  master N cycle (N=0 instruction bus, N=1 data bus; applies to REQ-006..REQ-015).
REQ-007 mN_stb_i  input  1  master N strobe.
REQ-008 mN_we_i  input  1  master N write enable.
REQ-009 mN_adr_i  input  ADW  master N word address.
REQ-010 mN_dat_i  input  DW  master N write data.
REQ-011 mN_sel_i  input  DW/8  master N byte select.
REQ-012 mN_dat_o  output  DW  read data to master N.
REQ-013 mN_ack_o  output  1  ack to master N.
REQ-014 mN_err_o  output  1  error to master N.
REQ-015 mN_gnt_o  output  1  master N currently owns slave.
REQ-016 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave cycle/strobe/write.
REQ-017 s_adr_o  output  ADW; s_dat_o  output  DW; s_sel_o  output  DW/8  slave address/data/select.
REQ-018 s_dat_i  input  DW; s_ack_i, s_err_i  input  1 each  slave response.

Function
REQ-019 FSM states IDLE, GNT0, GNT1; arbitration decided only in IDLE.
REQ-020 IDLE: one cyc high -> grant that master next cycle; both high -> grant master not granted last (round-robin); neither -> stay IDLE.
REQ-021 "Last granted" register SHALL reset to 0, so first tie after reset goes to master 1.
REQ-022 GNTn: stay while mn_cyc_i high; mn_cyc_i low -> IDLE next cycle; minimum one IDLE cycle between grants.
REQ-023 In GNTn, slave outputs SHALL be combinational copies of master n cyc/stb/we/adr/dat/sel; in IDLE all slave outputs 0.
REQ-024 s_dat_i SHALL drive both mN_dat_o unconditionally; ack/err SHALL reach only the granted master, other master's ack/err forced 0.
REQ-025 Zero added latency on granted path: slave ack in cycle k appears at master in cycle k.
REQ-026 Grant latency: cyc rising in cycle k with state IDLE -> s_cyc_o high in cycle k+1.
REQ-027 Watchdog counter, width clog2(TIMEOUT+1), increments each cycle s_stb_o=1 and s_ack_i=0 and s_err_i=0; clears on ack, err, or leaving GNTn.
REQ-028 Counter == TIMEOUT -> granted master's err_o high exactly one cycle, s_stb_o forced 0 that cycle, counter clears; grant retained.
REQ-029 s_ack_i and s_err_i both high -> pass both; master treats err as dominant, arbiter does not filter.
REQ-030 Granted master drops cyc while strobe pending -> s_cyc_o/s_stb_o fall same cycle (combinational), state IDLE next cycle.
REQ-031 Responses arriving in IDLE SHALL be discarded (no master ack/err).

Reset
REQ-032 rst low asynchronously forces IDLE, last-granted=0, counter=0; all slave outputs, mN_ack_o, mN_err_o, mN_gnt_o = 0 while low and in first cycle after release.
REQ-033 Reset asserted mid-transfer aborts it; no ack/err issued for the aborted strobe.

Verification
REQ-034 Only m0 cyc/stb, adr=0x100, slave acks 2 cycles later -> s_cyc_o at k+1, s_adr_o=0x100, m0_ack_o with slave ack, m1_ack_o=0.
REQ-035 m0 and m1 cyc rise same cycle after reset -> m1 granted first; after m1 drops cyc, one IDLE cycle, then m0 granted.
REQ-036 Both hold cyc continuously, 4 transactions each -> grants alternate 1,0,1,0...; no master granted twice in a row while other waits.
REQ-037 TIMEOUT=8, slave never responds -> granted master err_o pulses once 8 cycles after strobe, s_stb_o low that cycle, other master err_o=0.
REQ-038 rst low for 1 cycle mid-read (stb pending) -> all outputs 0 immediately, IDLE after release, no ack to aborted master.
REQ-039 Slave ack while IDLE (m0 dropped cyc same cycle) -> no mN_ack_o asserted.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Purpose : two-master Wishbone arbiter (m0 = instruction bus, m1 = data bus) onto one slave,
//           round-robin on ties, per-strobe watchdog that terminates a hung access with err.
// Latency : grant 1 cycle after cyc rises in IDLE; request/response paths are combinational (0 cycles).
// Backpres: the slave stalls the granted master by withholding ack; the losing master waits on gnt.
//
// Ports
//   clk, rst          : single clock, asynchronous active-low reset
//   mN_cyc/stb/we/adr/dat/sel_i : master N request (N=0,1)
//   mN_dat_o/ack_o/err_o/gnt_o  : master N response and grant indication
//   s_cyc/stb/we/adr/dat/sel_o  : request to the shared slave
//   s_dat_i/ack_i/err_i         : slave response
module wb_arbiter2 #(
    parameter int ADW     = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [ADW-1:0]  m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_gnt_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [ADW-1:0]  m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_gnt_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [ADW-1:0]  s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;     // master granted most recently (0 or 1)
    logic [CW-1:0]   wdog_q, wdog_d;     // cycles the current strobe has waited
    logic            timeout;

    // Watchdog expiry: terminate the strobe this cycle with err to the owner.
    assign timeout = (state_q != IDLE) && (wdog_q == TMO_VAL);

    // Read data is broadcast; only ack/err are steered.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // Tie: favour whoever did not own the bus last.
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
                if (state_d == GNT0) last_d = 1'b0;
                if (state_d == GNT1) last_d = 1'b1;
            end
            GNT0: if (!m0_cyc_i) state_d = IDLE;
            GNT1: if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Watchdog next value. Any response, expiry, or loss of ownership restarts it.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == IDLE || state_d == IDLE) begin
            wdog_d = '0;
        end else if (s_ack_i || s_err_i || timeout) begin
            wdog_d = '0;
        end else if (s_stb_o) begin
            wdog_d = wdog_q + CW'(1);
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_gnt_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_gnt_o = 1'b0;
        unique case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i && !timeout;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || timeout;
                m0_gnt_o = 1'b1;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i && !timeout;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || timeout;
                m1_gnt_o = 1'b1;
            end
            default: ; // IDLE: slave quiet, responses dropped
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

    localparam int ADW = 30;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            m_cyc [2];
    logic            m_stb [2];
    logic            m_we  [2];
    logic [ADW-1:0]  m_adr [2];
    logic [DW-1:0]   m_dat [2];
    logic [SW-1:0]   m_sel [2];
    logic [DW-1:0]   s_dat_in;
    logic            s_ack, s_err;

    logic [DW-1:0]   m0_dat_o, m1_dat_o;
    logic            m0_ack_o, m0_err_o, m0_gnt_o;
    logic            m1_ack_o, m1_err_o, m1_gnt_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [ADW-1:0]  s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter2 #(.ADW(ADW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst_n),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_gnt_o(m0_gnt_o),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_gnt_o(m1_gnt_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_in), .s_ack_i(s_ack), .s_err_i(s_err)
    );

    // Reference model: which master owns the slave (-1 = nobody), who owned it last,
    // and how long the owner's current strobe has gone unanswered.
    int owner  = -1;
    int last_g = 0;
    int wd     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner  <= -1;
            last_g <= 0;
            wd     <= 0;
        end else if (owner < 0) begin
            wd <= 0;
            if (m_cyc[0] && m_cyc[1]) begin
                owner  <= 1 - last_g;
                last_g <= 1 - last_g;
            end else if (m_cyc[0]) begin
                owner  <= 0;
                last_g <= 0;
            end else if (m_cyc[1]) begin
                owner  <= 1;
                last_g <= 1;
            end
        end else begin
            if (!m_cyc[owner])                  begin owner <= -1; wd <= 0; end
            else if (s_ack || s_err || wd == TMO) wd <= 0;
            else if (m_stb[owner])              wd <= wd + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        for (int n = 0; n < 2; n++) begin
            m_cyc[n] = 1'b0; m_stb[n] = 1'b0; m_we[n] = 1'b0;
            m_adr[n] = '0;   m_dat[n] = '0;   m_sel[n] = '0;
        end
        s_dat_in = '0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; s_ack = 1'b1; s_err = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o} !== '0) begin
            n_bad++; $display("FAIL reset_slave_outputs got %h want 0", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o});
        end
        n_cmp++;
        if ({m0_ack_o, m0_err_o, m0_gnt_o, m1_ack_o, m1_err_o, m1_gnt_o} !== 6'b0) begin
            n_bad++; $display("FAIL reset_master_outputs got %b want 000000", {m0_ack_o, m0_err_o, m0_gnt_o, m1_ack_o, m1_err_o, m1_gnt_o});
        end
        tick();
        s_ack = 1'b0; s_err = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_cyc_o, m0_gnt_o, m1_gnt_o, m0_ack_o} !== 4'b0) begin
            n_bad++; $display("FAIL post_release_quiet got %b want 0000", {s_cyc_o, m0_gnt_o, m1_gnt_o, m0_ack_o});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({m0_gnt_o, s_cyc_o} !== 2'b11) begin
            n_bad++; $display("FAIL post_release_grant got %b want 11", {m0_gnt_o, s_cyc_o});
        end
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_single;
        logic [DW-1:0] d;
        d = $urandom;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 30'h100; m_sel[0] = 4'hF;
        @(negedge clk);
        n_cmp++;
        if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL single_no_early_grant got %b want 0", s_cyc_o); end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({s_cyc_o, s_stb_o} !== 2'b11) begin n_bad++; $display("FAIL single_grant_latency got %b want 11", {s_cyc_o, s_stb_o}); end
        n_cmp++;
        if (s_adr_o !== 30'h100) begin n_bad++; $display("FAIL single_adr got %h want 100", s_adr_o); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (m0_ack_o !== 1'b0) begin n_bad++; $display("FAIL single_no_ack_yet got %b want 0", m0_ack_o); end
        tick();
        s_ack = 1'b1; s_dat_in = d;
        @(negedge clk);
        n_cmp++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10) begin n_bad++; $display("FAIL single_ack_route got %b want 10", {m0_ack_o, m1_ack_o}); end
        n_cmp++;
        if ({m0_dat_o, m1_dat_o} !== {d, d}) begin n_bad++; $display("FAIL single_read_data got %h/%h want %h", m0_dat_o, m1_dat_o, d); end
        tick();
        clear_inputs();
        @(negedge clk);
        n_cmp++;
        if ({s_cyc_o, s_stb_o, m0_gnt_o} !== 3'b001) begin n_bad++; $display("FAIL single_drop_comb got %b want 001", {s_cyc_o, s_stb_o, m0_gnt_o}); end
        tick();
        @(negedge clk);
        n_cmp++;
        if (m0_gnt_o !== 1'b0) begin n_bad++; $display("FAIL single_release got %b want 0", m0_gnt_o); end
        tick();
    endtask

    task automatic test_tie;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[0] = 1'b1; m_stb[1] = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin n_bad++; $display("FAIL tie_first_m1 got %b want 01", {m0_gnt_o, m1_gnt_o}); end
        tick();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b00) begin n_bad++; $display("FAIL tie_idle_gap got %b want 00", {m0_gnt_o, m1_gnt_o}); end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({m0_gnt_o, m1_gnt_o} !== 2'b10) begin n_bad++; $display("FAIL tie_then_m0 got %b want 10", {m0_gnt_o, m1_gnt_o}); end
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    // Both masters keep requesting; each drops cyc for one cycle after its transfer.
    task automatic test_back_to_back;
        int exp_g;
        int g;
        bit found;
        exp_g = 1;
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                @(negedge clk);
                if (m0_gnt_o || m1_gnt_o) found = 1'b1;
                else tick();
            end
            n_cmp++;
            if (!found) begin n_bad++; $display("FAIL b2b_grant_wait got none want grant %0d", exp_g); break; end
            g = m1_gnt_o ? 1 : 0;
            n_cmp++;
            if (g != exp_g) begin n_bad++; $display("FAIL b2b_order txn %0d got %0d want %0d", t, g, exp_g); end
            tick();
            m_stb[g] = 1'b1; m_adr[g] = 30'($urandom);
            tick();
            s_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({m0_ack_o, m1_ack_o} !== ((g == 1) ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL b2b_ack_route txn %0d got %b want master %0d", t, {m0_ack_o, m1_ack_o}, g);
            end
            tick();
            s_ack = 1'b0; m_stb[g] = 1'b0; m_cyc[g] = 1'b0;
            tick();
            m_cyc[g] = 1'b1;
            exp_g = 1 - exp_g;
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout;
        int hit;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (s_stb_o !== 1'b1) begin n_bad++; $display("FAIL tmo_strobe_start got %b want 1", s_stb_o); end
        hit = 0;
        for (int i = 1; i <= 12 && hit == 0; i++) begin
            tick();
            @(negedge clk);
            if (m1_err_o) hit = i;
        end
        n_cmp++;
        if (hit != TMO) begin n_bad++; $display("FAIL tmo_delay got %0d want %0d", hit, TMO); end
        n_cmp++;
        if ({s_stb_o, m0_err_o, m1_gnt_o, s_cyc_o} !== 4'b0011) begin
            n_bad++; $display("FAIL tmo_err_cycle got %b want 0011", {s_stb_o, m0_err_o, m1_gnt_o, s_cyc_o});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({m1_err_o, s_stb_o} !== 2'b01) begin n_bad++; $display("FAIL tmo_single_pulse got %b want 01", {m1_err_o, s_stb_o}); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        tick();
        rst_n = 1'b0; s_ack = 1'b1;
        #1;
        n_cmp++;
        if ({s_cyc_o, s_stb_o, m0_gnt_o, m0_ack_o, m0_err_o} !== 5'b0) begin
            n_bad++; $display("FAIL rstmid_immediate got %b want 00000", {s_cyc_o, s_stb_o, m0_gnt_o, m0_ack_o, m0_err_o});
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({s_cyc_o, m0_gnt_o, m0_ack_o, m1_ack_o} !== 4'b0) begin
            n_bad++; $display("FAIL rstmid_after_release got %b want 0000", {s_cyc_o, m0_gnt_o, m0_ack_o, m1_ack_o});
        end
        tick();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_idle_response;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        s_ack = 1'b1; s_err = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) begin
            n_bad++; $display("FAIL idle_response_dropped got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_random;
        logic [31:0]     r;
        logic            e_cyc, e_stb, e_we, tmo;
        logic [ADW-1:0]  e_adr;
        logic [DW-1:0]   e_dat;
        logic [SW-1:0]   e_sel;
        logic [1:0]      e_ack, e_err, e_gnt;
        logic [138:0]    exp_v, act_v;
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 7) == 0) m_cyc[n] = ~m_cyc[n];
                m_stb[n] = m_cyc[n] & 1'($urandom_range(0, 1));
                m_we[n]  = 1'($urandom_range(0, 1));
                r = $urandom; m_adr[n] = r[ADW-1:0];
                m_dat[n] = $urandom;
                r = $urandom; m_sel[n] = r[SW-1:0];
            end
            s_dat_in = $urandom;
            // Alternate responsive and silent slave phases so the watchdog fires.
            s_ack = ((i % 100) < 50) ? ($urandom_range(0, 2) == 0) : 1'b0;
            s_err = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
            e_ack = 2'b0; e_err = 2'b0; e_gnt = 2'b0;
            tmo = (owner >= 0) && (wd == TMO);
            if (owner >= 0) begin
                e_cyc = m_cyc[owner];
                e_stb = m_stb[owner] && !tmo;
                e_we  = m_we[owner];
                e_adr = m_adr[owner];
                e_dat = m_dat[owner];
                e_sel = m_sel[owner];
                e_ack[owner] = s_ack;
                e_err[owner] = s_err || tmo;
                e_gnt[owner] = 1'b1;
            end
            exp_v = {e_cyc, e_stb, e_we, e_adr, e_dat, e_sel, e_ack, e_err, e_gnt, s_dat_in, s_dat_in};
            act_v = {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
                     m1_ack_o, m0_ack_o, m1_err_o, m0_err_o, m1_gnt_o, m0_gnt_o, m0_dat_o, m1_dat_o};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++; $display("FAIL random cycle %0d got %h want %h", i, act_v, exp_v);
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit got no finish want finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_idle_response();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
